// File: rtl/fuzzy_input_serializer_pkg.sv
// fuzzy_ser_pkg: shared types and constants for the fuzzy input serializer.
// Optional frame counter in the top is enabled with `define FUZZ_SER_FRAME_CNT_EN.
package fuzzy_ser_pkg;

   // Control FSM states of the serializer
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   // Crisp input width expected by the fuzzification receiver (index 9..0)
   localparam int DEFAULT_INPUT_WIDTH = 10;

   // Width of the inter-frame gap counter (supports 0..15 idle cycles)
   localparam int GAP_CNT_W = 4;

   // Width of the optional frame counter
   localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/fuzzy_input_serializer_shift_lane.sv
// fuzzy_shift_lane: single-input parallel-in / serial-out lane, MSB first.
// Load has priority over shift; shifting fills with zeros so an exhausted
// lane presents 0 on its MSB.
module fuzzy_shift_lane
#(
   parameter int WIDTH = 10
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] data,
   output logic             msb
);

   logic [WIDTH-1:0] shift_reg;

   // Capture a new word on load, otherwise move the next bit into the MSB
   always_ff @(posedge clock) begin
      if (reset) begin
         shift_reg <= '0;
      end else if (load) begin
         shift_reg <= data;
      end else if (shift) begin
         shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
      end
   end

   assign msb = shift_reg[WIDTH-1];

endmodule

// File: rtl/fuzzy_input_serializer.sv
// fuzzy_input_serializer: accepts a pair of crisp words on a valid/ready
// handshake and streams them MSB first as start + two serial bits, one
// frame of INPUT_WIDTH cycles per pair, optionally followed by GAP_CYCLES
// idle cycles. All outputs are driven from registers.
// Define FUZZ_SER_FRAME_CNT_EN to add the frame_count / frame_pulse outputs.
module fuzzy_input_serializer
   import fuzzy_ser_pkg::*;
#(
   parameter int INPUT_WIDTH = DEFAULT_INPUT_WIDTH,
   parameter int GAP_CYCLES  = 0
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [INPUT_WIDTH-1:0] in_data_0,
   input  logic [INPUT_WIDTH-1:0] in_data_1,
   output logic                   out_start,
   output logic                   out_inputs_0,
   output logic                   out_inputs_1,
   output logic                   out_last,
   output logic                   busy
`ifdef FUZZ_SER_FRAME_CNT_EN
   ,
   output logic [FRAME_CNT_W-1:0] frame_count,
   output logic                   frame_pulse
`endif
);

   localparam int CNT_W = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1;
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(INPUT_WIDTH - 1);
   localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
   localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [GAP_CNT_W-1:0] GAP_ONE  = GAP_CNT_W'(1);
   localparam bit                   HAS_GAP  = (GAP_CYCLES > 0);

   state_t               state_reg;
   logic [CNT_W-1:0]     bit_cnt_reg;
   logic [GAP_CNT_W-1:0] gap_cnt_reg;
   logic                 start_reg;
   logic                 last_reg;
   logic                 ready_reg;
   logic                 busy_reg;

   logic                 accept;
   logic                 lane_load;
   logic                 lane_shift;
   logic [INPUT_WIDTH-1:0] lane_data [2];
   logic                 lane_msb  [2];

   // A pair is taken only on the handshake; ready is a register, so there is
   // no combinational path from in_valid back to in_ready.
   assign accept     = in_valid & ready_reg;
   assign lane_load  = accept;
   assign lane_shift = (state_reg == SHIFT);

   assign lane_data[0] = in_data_0;
   assign lane_data[1] = in_data_1;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_lane
         fuzzy_shift_lane #(
            .WIDTH (INPUT_WIDTH)
         ) u_lane (
            .clock (clock),
            .reset (reset),
            .load  (lane_load),
            .shift (lane_shift),
            .data  (lane_data[gi]),
            .msb   (lane_msb[gi])
         );
      end
   endgenerate

   // Control FSM: frame sequencing, bit/gap counters and registered status outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg   <= IDLE;
         bit_cnt_reg <= CNT_LAST;
         gap_cnt_reg <= '0;
         start_reg   <= 1'b0;
         last_reg    <= 1'b0;
         ready_reg   <= 1'b1;
         busy_reg    <= 1'b0;
      end else begin
         unique case (state_reg)
            IDLE: begin
               if (accept) begin
                  state_reg   <= SHIFT;
                  bit_cnt_reg <= CNT_LAST;
                  start_reg   <= 1'b1;
                  last_reg    <= 1'b0;
                  ready_reg   <= 1'b0;
                  busy_reg    <= 1'b1;
               end
            end
            SHIFT: begin
               if (bit_cnt_reg == '0) begin
                  if (HAS_GAP) begin
                     state_reg   <= GAP;
                     gap_cnt_reg <= GAP_LAST;
                     start_reg   <= 1'b0;
                     last_reg    <= 1'b0;
                     ready_reg   <= 1'b0;
                     busy_reg    <= 1'b1;
                  end else if (accept) begin
                     // Back-to-back: next MSB directly follows this LSB
                     bit_cnt_reg <= CNT_LAST;
                     start_reg   <= 1'b1;
                     last_reg    <= 1'b0;
                     ready_reg   <= 1'b0;
                     busy_reg    <= 1'b1;
                  end else begin
                     state_reg   <= IDLE;
                     bit_cnt_reg <= CNT_LAST;
                     start_reg   <= 1'b0;
                     last_reg    <= 1'b0;
                     ready_reg   <= 1'b1;
                     busy_reg    <= 1'b0;
                  end
               end else begin
                  bit_cnt_reg <= bit_cnt_reg - CNT_ONE;
                  last_reg    <= (bit_cnt_reg == CNT_ONE);
                  ready_reg   <= (bit_cnt_reg == CNT_ONE) && !HAS_GAP;
               end
            end
            GAP: begin
               if (gap_cnt_reg == '0) begin
                  state_reg   <= IDLE;
                  bit_cnt_reg <= CNT_LAST;
                  ready_reg   <= 1'b1;
                  busy_reg    <= 1'b0;
               end else begin
                  gap_cnt_reg <= gap_cnt_reg - GAP_ONE;
               end
            end
            default: begin
               state_reg   <= IDLE;
               bit_cnt_reg <= CNT_LAST;
               start_reg   <= 1'b0;
               last_reg    <= 1'b0;
               ready_reg   <= 1'b1;
               busy_reg    <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready     = ready_reg;
   assign out_start    = start_reg;
   assign out_last     = last_reg;
   assign busy         = busy_reg;
   // Lane MSBs are registers; gating with start keeps idle/gap outputs at 0
   assign out_inputs_0 = lane_msb[0] & start_reg;
   assign out_inputs_1 = lane_msb[1] & start_reg;

`ifdef FUZZ_SER_FRAME_CNT_EN
   logic [FRAME_CNT_W-1:0] frame_count_reg;
   logic                   frame_pulse_reg;

   // Count completed frames (wrapping) and pulse once after each final bit
   always_ff @(posedge clock) begin
      if (reset) begin
         frame_count_reg <= '0;
         frame_pulse_reg <= 1'b0;
      end else begin
         frame_pulse_reg <= last_reg;
         if (last_reg) begin
            frame_count_reg <= frame_count_reg + FRAME_CNT_W'(1);
         end
      end
   end

   assign frame_count = frame_count_reg;
   assign frame_pulse = frame_pulse_reg;
`endif

endmodule

// File: tb/tb_fuzzy_input_serializer.sv
// Scoreboard bench for fuzzy_input_serializer. Two instances run side by
// side: lane 0 with no gap, lane 1 with a 3-cycle gap. Every accepted pair is
// expanded into its expected bit stream (time-stamped by accept edge) and a
// monitor compares the outputs of both instances every cycle.
// Build with FUZZ_SER_FRAME_CNT_EN defined to also check the frame counter.
module tb_fuzzy_input_serializer;
   import fuzzy_ser_pkg::*;

   localparam int W    = DEFAULT_INPUT_WIDTH;
   localparam int GAP1 = 3;

   typedef struct {
      int due;
      bit b0;
      bit b1;
      bit last;
   } exp_t;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid [2];
   logic [W-1:0] d0       [2];
   logic [W-1:0] d1       [2];
   logic         s_ready  [2];
   logic         s_start  [2];
   logic         s_b0     [2];
   logic         s_b1     [2];
   logic         s_last   [2];
   logic         s_busy   [2];
`ifdef FUZZ_SER_FRAME_CNT_EN
   logic [15:0]  s_fcnt   [2];
   logic         s_fpulse [2];
   logic [15:0]  fc       [2];
   bit           pulse_exp[2];
`endif

   exp_t         exp_q  [2][$];
   logic [2*W-1:0] stim_q [2][$];
   bit           hold     [2];
   int           last_end [2];
   int           cyc      = 0;
   bit           rst_edge = 1'b0;
   bit           mon_en   = 1'b0;
   int           rand_pct = 0;
   int           n_cmp    = 0;
   int           n_fail   = 0;

   always #5 clock = ~clock;

   always @(posedge clock) begin
      cyc      <= cyc + 1;
      rst_edge <= reset;
   end

   fuzzy_input_serializer #(.INPUT_WIDTH(W), .GAP_CYCLES(0)) dut0 (
      .clock(clock), .reset(reset), .in_valid(in_valid[0]), .in_ready(s_ready[0]),
      .in_data_0(d0[0]), .in_data_1(d1[0]), .out_start(s_start[0]),
      .out_inputs_0(s_b0[0]), .out_inputs_1(s_b1[0]), .out_last(s_last[0]),
      .busy(s_busy[0])
`ifdef FUZZ_SER_FRAME_CNT_EN
      , .frame_count(s_fcnt[0]), .frame_pulse(s_fpulse[0])
`endif
   );

   fuzzy_input_serializer #(.INPUT_WIDTH(W), .GAP_CYCLES(GAP1)) dut1 (
      .clock(clock), .reset(reset), .in_valid(in_valid[1]), .in_ready(s_ready[1]),
      .in_data_0(d0[1]), .in_data_1(d1[1]), .out_start(s_start[1]),
      .out_inputs_0(s_b0[1]), .out_inputs_1(s_b1[1]), .out_last(s_last[1]),
      .busy(s_busy[1])
`ifdef FUZZ_SER_FRAME_CNT_EN
      , .frame_count(s_fcnt[1]), .frame_pulse(s_fpulse[1])
`endif
   );

   // Expected stream of one accepted pair: bit i of the frame appears i
   // cycles after the accepting edge, MSB first, last flag on the LSB.
   task automatic push_frame(input int k, input int t, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      for (int i = 0; i < W; i++) begin
         e.due  = t + i;
         e.b0   = a[W-1-i];
         e.b1   = b[W-1-i];
         e.last = (i == W - 1);
         exp_q[k].push_back(e);
      end
      last_end[k] = t + W - 1;
   endtask

   // Monitor for one instance, called on the falling edge
   task automatic check_lane(input int k);
      exp_t       e;
      logic [5:0] got;
      logic [5:0] want;
      bit         in_gap;
      bit         is_last;
      int         g;
      g       = (k == 0) ? 0 : GAP1;
      is_last = 1'b0;
      if (rst_edge) begin
         exp_q[k].delete();
         last_end[k] = -1000;
`ifdef FUZZ_SER_FRAME_CNT_EN
         fc[k]        = 16'h0000;
         pulse_exp[k] = 1'b0;
`endif
      end
      while (exp_q[k].size() > 0 && exp_q[k][0].due < cyc) begin
         e = exp_q[k].pop_front();
         n_cmp++;
         n_fail++;
         $display("FAIL lane%0d missing_bit: bit due at cycle %0d not presented (now cycle %0d)", k, e.due, cyc);
      end
      in_gap = (cyc > last_end[k]) && (cyc <= last_end[k] + g);
      if (exp_q[k].size() > 0 && exp_q[k][0].due == cyc) begin
         e       = exp_q[k].pop_front();
         is_last = e.last;
         want    = {1'b1, e.b0, e.b1, e.last, (e.last && g == 0), 1'b1};
      end else begin
         want = {4'b0000, !in_gap, in_gap};
      end
      got = {s_start[k], s_b0[k], s_b1[k], s_last[k], s_ready[k], s_busy[k]};
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL lane%0d outputs cycle %0d {start,b0,b1,last,ready,busy}: got %b expected %b", k, cyc, got, want);
      end
`ifdef FUZZ_SER_FRAME_CNT_EN
      n_cmp++;
      if (s_fcnt[k] !== fc[k] || s_fpulse[k] !== pulse_exp[k]) begin
         n_fail++;
         $display("FAIL lane%0d frame_cnt cycle %0d: got count %h pulse %b expected count %h pulse %b",
                  k, cyc, s_fcnt[k], s_fpulse[k], fc[k], pulse_exp[k]);
      end
      if (is_last) fc[k] = fc[k] + 16'h0001;
      pulse_exp[k] = is_last;
`endif
   endtask

   always @(negedge clock) begin
      if (mon_en) begin
         for (int k = 0; k < 2; k++) check_lane(k);
      end
   end

   // One driver cycle: present a pair (directed, random or none), hold it
   // until accepted, and record the expected stream on the handshake.
   task automatic step();
      logic [2*W-1:0] p;
      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
         if (!hold[k]) begin
            if (stim_q[k].size() > 0) begin
               p           = stim_q[k].pop_front();
               in_valid[k] = 1'b1;
               d0[k]       = p[2*W-1:W];
               d1[k]       = p[W-1:0];
            end else begin
               in_valid[k] = (rand_pct > 0) && ($urandom_range(99) < rand_pct);
               d0[k]       = W'($urandom);
               d1[k]       = W'($urandom);
            end
         end
         if (in_valid[k] && s_ready[k]) begin
            push_frame(k, cyc + 1, d0[k], d1[k]);
            hold[k] = 1'b0;
         end else begin
            hold[k] = in_valid[k];
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         in_valid[k] = 1'b0;
         hold[k]     = 1'b0;
      end
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic push_both(input logic [W-1:0] a, input logic [W-1:0] b);
      stim_q[0].push_back({a, b});
      stim_q[1].push_back({a, b});
   endtask

   initial begin
      bit reached;
      for (int k = 0; k < 2; k++) begin
         in_valid[k] = 1'b0;
         d0[k]       = '0;
         d1[k]       = '0;
         hold[k]     = 1'b0;
         last_end[k] = -1000;
`ifdef FUZZ_SER_FRAME_CNT_EN
         fc[k]        = 16'h0000;
         pulse_exp[k] = 1'b0;
`endif
      end
      reset = 1'b1;
      repeat (3) @(negedge clock);
      mon_en = 1'b1;
      reset  = 1'b0;

      // Idle with in_data noise: nothing must start
      rand_pct = 0;
      repeat (20) step();

      // Single frame, then a back-to-back pair
      push_both(10'h2A5, 10'h0F0);
      repeat (30) step();
      push_both(10'h3FF, 10'h000);
      push_both(10'h000, 10'h3FF);
      repeat (45) step();

      // Random traffic, then continuous valid, then drain
      rand_pct = 50;
      repeat (400) step();
      rand_pct = 100;
      repeat (200) step();
      rand_pct = 0;
      repeat (30) step();

      // Reset in the middle of a lane-0 frame
      stim_q[0].push_back({10'h1C3, 10'h26B});
      reached = 1'b0;
      for (int n = 0; n < 50 && !reached; n++) begin
         step();
         if (exp_q[0].size() > 0 && exp_q[0].size() <= W - 5) reached = 1'b1;
      end
      n_cmp++;
      if (!reached) begin
         n_fail++;
         $display("FAIL mid_frame_wait: frame never reached bit 5 (got no progress, required within 50 cycles)");
      end
      do_reset();
      push_both(10'h155, 10'h2AA);
      repeat (30) step();

`ifdef FUZZ_SER_FRAME_CNT_EN
      // Three frames, then wrap from 0xFFFF
      repeat (3) stim_q[0].push_back({10'h0AB, 10'h354});
      repeat (50) step();
      @(negedge clock);
      force dut0.frame_count_reg = 16'hFFFF;
      #1;
      release dut0.frame_count_reg;
      fc[0] = 16'hFFFF;
      stim_q[0].push_back({10'h3C3, 10'h03C});
      repeat (20) step();
`endif

      repeat (5) step();
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (exp_q[k].size() != 0) begin
            n_fail++;
            $display("FAIL lane%0d drain: %0d expected bits left, required 0", k, exp_q[k].size());
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
